// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch queue bus: instruction memory port plus decode-side issue port
interface instr_fetch_queue_if #(
    parameter int PC_W = 16
);
    logic            imem_rd_en;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            stall;
    logic            flush;
    logic [PC_W-1:0] flush_target;
    logic [15:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            halted;

    modport master (
        output imem_rd_en, imem_addr, instr, instr_pc, instr_valid, halted,
        input  imem_data, stall, flush, flush_target
    );

    modport slave (
        input  imem_rd_en, imem_addr, instr, instr_pc, instr_valid, halted,
        output imem_data, stall, flush, flush_target
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential instruction fetch with DEPTH-entry queue, redirect and HLT stop
// Optional same-cycle bypass of the memory response when the queue is empty: define FETCH_BYPASS_EN.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_queue_if.master   bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 2;
    localparam logic [15:0] NOP = 16'h4000;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            fetch_stop_q, fetch_stop_d;
    logic            halted_q, halted_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;

    logic [15:0]     fifo_instr_q [DEPTH];
    logic [PC_W-1:0] fifo_pc_q    [DEPTH];

    logic            arrive;
    logic            bypass;
    logic            req;
    logic            push;
    logic            pop;
    logic            pop_fifo;
    logic            head_valid;
    logic [15:0]     head_instr;
    logic [PC_W-1:0] head_pc;
    logic [OCC_W-1:0] occupancy;

    always_comb begin
        arrive = inflight_q && !bus.flush;
`ifdef FETCH_BYPASS_EN
        bypass = arrive && (count_q == '0);
`else
        bypass = 1'b0;
`endif
        head_valid = (count_q != '0) || bypass;
        head_instr = bypass ? bus.imem_data : fifo_instr_q[head_q];
        head_pc    = bypass ? req_pc_q      : fifo_pc_q[head_q];
        pop        = head_valid && !bus.stall && !bus.flush;
        // A bypassed word that decode accepts never occupies a slot.
        push       = arrive && !(bypass && pop);
        pop_fifo   = pop && !bypass;
        // Slots are reserved at request time so a response always finds room.
        occupancy  = {1'b0, count_q} + {{(OCC_W-1){1'b0}}, inflight_q};
        req        = !rst && !bus.flush && !fetch_stop_q && (occupancy < OCC_W'(DEPTH));
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        inflight_d   = 1'b0;
        fetch_stop_d = fetch_stop_q;
        halted_d     = halted_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        if (bus.flush) begin
            fetch_pc_d   = bus.flush_target;
            fetch_stop_d = 1'b0;
            halted_d     = 1'b0;
            count_d      = '0;
            head_d       = '0;
            tail_d       = '0;
        end else begin
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop_fifo);
            tail_d  = tail_q + AW'(push);
            head_d  = head_q + AW'(pop_fifo);
            if (req) begin
                fetch_pc_d = fetch_pc_q + PC_W'(2);
                req_pc_d   = fetch_pc_q;
                inflight_d = 1'b1;
            end
            if (arrive && (bus.imem_data[15:12] == 4'hF)) begin
                fetch_stop_d = 1'b1;
            end
            if (pop && (head_instr[15:12] == 4'hF)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= '0;
            req_pc_q     <= '0;
            inflight_q   <= 1'b0;
            fetch_stop_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            inflight_q   <= inflight_d;
            fetch_stop_q <= fetch_stop_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    // Storage needs no reset: an entry is only read while count covers it.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            fifo_instr_q[tail_q] <= bus.imem_data;
            fifo_pc_q[tail_q]    <= req_pc_q;
        end
    end

    assign bus.imem_rd_en  = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? head_instr : NOP;
    assign bus.instr_pc    = head_valid ? head_pc : '0;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed bench for instr_fetch_queue, both with and without FETCH_BYPASS_EN
module tb_instr_fetch_queue;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hlt_at4 = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instr_fetch_queue_if #(.PC_W(16)) bus ();

    instr_fetch_queue #(.DEPTH(4), .PC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0123;
        if (a == 16'h0002) return 16'h1456;
        if (hlt_at4 && a == 16'h0004) return 16'hF000;
        return 16'h2000 | {4'h0, a[11:0]};
    endfunction

    // Instruction memory: word valid the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_data <= mem_word(bus.imem_addr);
        else                bus.imem_data <= 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.flush_target = 16'h0000;
        bus.imem_data = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'h4000);
        chk("rst_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);

        // Streaming, stall=0
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("s_c0_rd", 32'(bus.imem_rd_en), 32'd1);
        chk("s_c0_addr", 32'(bus.imem_addr), 32'h0);
        chk("s_c0_valid", 32'(bus.instr_valid), 32'd0);
        cyc(); #1;
        chk("s_c1_addr", 32'(bus.imem_addr), 32'h2);
        chk("s_c1_valid", 32'(bus.instr_valid), 32'(BYP));
        chk("s_c1_instr", 32'(bus.instr), BYP ? 32'h0123 : 32'h4000);
        cyc(); #1;
        chk("s_c2_addr", 32'(bus.imem_addr), 32'h4);
        chk("s_c2_valid", 32'(bus.instr_valid), 32'd1);
        chk("s_c2_instr", 32'(bus.instr), BYP ? 32'h1456 : 32'h0123);
        chk("s_c2_pc", 32'(bus.instr_pc), BYP ? 32'h2 : 32'h0);
        cyc(); #1;
        chk("s_c3_addr", 32'(bus.imem_addr), 32'h6);
        chk("s_c3_instr", 32'(bus.instr), BYP ? 32'h2004 : 32'h1456);
        chk("s_c3_pc", 32'(bus.instr_pc), BYP ? 32'h4 : 32'h2);

        // Fill under stall, then drain
        bus.stall = 1'b1;
        do_reset();
        chk("f_c0_addr", 32'(bus.imem_addr), 32'h0);
        cyc(); #1; chk("f_c1_addr", 32'(bus.imem_addr), 32'h2);
        cyc(); #1; chk("f_c2_addr", 32'(bus.imem_addr), 32'h4);
        cyc(); #1;
        chk("f_c3_rd", 32'(bus.imem_rd_en), 32'd1);
        chk("f_c3_addr", 32'(bus.imem_addr), 32'h6);
        cyc(); #1;
        chk("f_c4_rd", 32'(bus.imem_rd_en), 32'd0);
        chk("f_c4_valid", 32'(bus.instr_valid), 32'd1);
        chk("f_c4_pc", 32'(bus.instr_pc), 32'h0);
        chk("f_c4_instr", 32'(bus.instr), 32'h0123);
        cyc(); #1;
        chk("f_c5_rd", 32'(bus.imem_rd_en), 32'd0);
        chk("f_c5_pc", 32'(bus.instr_pc), 32'h0);
        cyc(); bus.stall = 1'b0; #1;
        chk("f_c6_rd", 32'(bus.imem_rd_en), 32'd0);
        chk("f_c6_pc", 32'(bus.instr_pc), 32'h0);
        cyc(); #1;
        chk("f_c7_rd", 32'(bus.imem_rd_en), 32'd1);
        chk("f_c7_addr", 32'(bus.imem_addr), 32'h8);
        chk("f_c7_pc", 32'(bus.instr_pc), 32'h2);
        cyc(); #1; chk("f_c8_pc", 32'(bus.instr_pc), 32'h4);
        cyc(); #1; chk("f_c9_pc", 32'(bus.instr_pc), 32'h6);
        cyc(); #1;
        chk("f_c10_pc", 32'(bus.instr_pc), 32'h8);
        chk("f_c10_instr", 32'(bus.instr), 32'h2008);

        // Flush with addr 6 in flight and two entries queued
        bus.stall = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc(); bus.stall = 1'b0; #1;
        chk("x_c3_pc", 32'(bus.instr_pc), 32'h0);
        chk("x_c3_addr", 32'(bus.imem_addr), 32'h6);
        cyc(); bus.stall = 1'b1; bus.flush = 1'b1; bus.flush_target = 16'h0040; #1;
        chk("x_c4_rd", 32'(bus.imem_rd_en), 32'd0);
        chk("x_c4_pc", 32'(bus.instr_pc), 32'h2);
        cyc(); bus.flush = 1'b0; #1;
        chk("x_c5_valid", 32'(bus.instr_valid), 32'd0);
        chk("x_c5_instr", 32'(bus.instr), 32'h4000);
        chk("x_c5_pc", 32'(bus.instr_pc), 32'h0);
        chk("x_c5_addr", 32'(bus.imem_addr), 32'h40);
        chk("x_c5_rd", 32'(bus.imem_rd_en), 32'd1);
        cyc(); bus.stall = 1'b0; #1;
        chk("x_c6_valid", 32'(bus.instr_valid), 32'(BYP));
        chk("x_c6_addr", 32'(bus.imem_addr), 32'h42);
        cyc(); #1;
        chk("x_c7_pc", 32'(bus.instr_pc), BYP ? 32'h42 : 32'h40);
        chk("x_c7_instr", 32'(bus.instr), BYP ? 32'h2042 : 32'h2040);

        // Reset while three entries are queued
        bus.stall = 1'b1;
        do_reset();
        repeat (4) cyc();
        #1;
        chk("r_c4_valid", 32'(bus.instr_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("r_rst_instr", 32'(bus.instr), 32'h4000);
        chk("r_rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("r_rst_halted", 32'(bus.halted), 32'd0);
        chk("r_rst_rd", 32'(bus.imem_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk("r_c0_rd", 32'(bus.imem_rd_en), 32'd1);
        chk("r_c0_addr", 32'(bus.imem_addr), 32'h0);
        cyc(); #1;
        chk("r_c1_instr", 32'(bus.instr), BYP ? 32'h0123 : 32'h4000);

        // HLT at addr 4, then redirect to 0x0010
        hlt_at4 = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc(); #1;
        chk("h_c3_addr", 32'(bus.imem_addr), 32'h6);
        cyc(); #1;
        chk("h_c4_rd", 32'(bus.imem_rd_en), 32'd0);
        chk("h_c4_halted", 32'(bus.halted), 32'(BYP));
        cyc(); #1;
        chk("h_c5_rd", 32'(bus.imem_rd_en), 32'd0);
        chk("h_c5_halted", 32'(bus.halted), 32'd1);
        cyc(); #1;
        chk("h_c6_valid", 32'(bus.instr_valid), 32'd0);
        chk("h_c6_rd", 32'(bus.imem_rd_en), 32'd0);
        bus.flush = 1'b1;
        bus.flush_target = 16'h0010;
        #1;
        chk("h_fl_halted", 32'(bus.halted), 32'd1);
        cyc(); bus.flush = 1'b0; #1;
        chk("h_c7_halted", 32'(bus.halted), 32'd0);
        chk("h_c7_rd", 32'(bus.imem_rd_en), 32'd1);
        chk("h_c7_addr", 32'(bus.imem_addr), 32'h10);
        cyc(); #1;
        chk("h_c8_addr", 32'(bus.imem_addr), 32'h12);
        cyc(); #1;
        chk("h_c9_pc", 32'(bus.instr_pc), BYP ? 32'h12 : 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
